// File: rtl/id_ex_ctrl_pipe_pkg.sv
// Shared types for the ID->EX control bundle: jump-type encodings, EX opcode
// width and the packed EX control struct used by both decode and execute.
package id_ex_ctrl_pipe_pkg;

  localparam int EX_OP_W = 3;

  typedef enum logic [1:0] {
    JT_NONE   = 2'b00,
    JT_JAL    = 2'b01,
    JT_JALR   = 2'b10,
    JT_BRANCH = 2'b11
  } jump_t_e;

  typedef struct packed {
    logic [EX_OP_W-1:0] ex;
    jump_t_e            jump_t;
    logic               slt;
    logic               lui;
    logic               mem_read;
    logic               mem_write;
    logic               reg_write;
  } ex_ctrl_t;

  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    ex:        '0,
    jump_t:    JT_NONE,
    slt:       1'b0,
    lui:       1'b0,
    mem_read:  1'b0,
    mem_write: 1'b0,
    reg_write: 1'b0
  };

endpackage

// File: rtl/id_ex_ctrl_pipe_load_use_detect.sv
// Combinational load-use hazard compare between the load sitting in EX and
// the register sources of the instruction in ID.
module id_ex_ctrl_pipe_load_use_detect #(
  parameter int REG_AW = 5
) (
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              id_valid,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  output logic              load_use
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
    rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
    // x0 is hard-wired, so a load targeting it never produces a hazard
    load_use = ex_valid && ex_mem_read && (ex_rd != '0) && id_valid && (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// ID->EX pipeline register with load-use bubble insertion, memory-stall hold
// and branch flush. Optional macro ID_EX_PERF_CNT_EN adds bubble/flush counters.
module id_ex_ctrl_pipe
  import id_ex_ctrl_pipe_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [EX_OP_W-1:0] id_ex,
  input  logic [1:0]         id_jump_t,
  input  logic               id_slt,
  input  logic               id_lui,
  input  logic               id_mem_read,
  input  logic               id_mem_write,
  input  logic               id_reg_write,
  input  logic               id_use_rs1,
  input  logic               id_use_rs2,
  input  logic [REG_AW-1:0]  id_rs1,
  input  logic [REG_AW-1:0]  id_rs2,
  input  logic [REG_AW-1:0]  id_rd,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic [XLEN-1:0]    id_pc,
  input  logic               ex_flush,
  input  logic               mem_hold,
  output logic               stall_id,
  output logic               ex_valid,
  output logic [EX_OP_W-1:0] ex_ex,
  output logic [1:0]         ex_jump_t,
  output logic               ex_slt,
  output logic               ex_lui,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic               ex_reg_write,
  output logic [REG_AW-1:0]  ex_rs1,
  output logic [REG_AW-1:0]  ex_rs2,
  output logic [REG_AW-1:0]  ex_rd,
  output logic [XLEN-1:0]    ex_rs1_data,
  output logic [XLEN-1:0]    ex_rs2_data,
  output logic [XLEN-1:0]    ex_imm,
`ifdef ID_EX_PERF_CNT_EN
  output logic [31:0]        perf_bubble_cnt,
  output logic [31:0]        perf_flush_cnt,
`endif
  output logic [XLEN-1:0]    ex_pc
);

  ex_ctrl_t          ctrl_p0;
  ex_ctrl_t          ctrl_p1;
  logic              vld_p1;
  logic [REG_AW-1:0] rs1_p1, rs2_p1, rd_p1;
  logic [XLEN-1:0]   rs1_data_p1, rs2_data_p1, imm_p1, pc_p1;
  logic              load_use;

  // ---- p0: decode-side bundle, controls squashed for empty ID slots ----
  always_comb begin
    ctrl_p0 = EX_CTRL_BUBBLE;
    if (id_valid) begin
      ctrl_p0.ex        = id_ex;
      ctrl_p0.jump_t    = jump_t_e'(id_jump_t);
      ctrl_p0.slt       = id_slt;
      ctrl_p0.lui       = id_lui;
      ctrl_p0.mem_read  = id_mem_read;
      ctrl_p0.mem_write = id_mem_write;
      ctrl_p0.reg_write = id_reg_write;
    end
  end

  id_ex_ctrl_pipe_load_use_detect #(.REG_AW(REG_AW)) u_load_use_detect (
    .ex_valid    (vld_p1),
    .ex_mem_read (ctrl_p1.mem_read),
    .ex_rd       (rd_p1),
    .id_valid    (id_valid),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .load_use    (load_use)
  );

  // A flush kills the ID instruction upstream, so there is nothing to hold
  assign stall_id = !ex_flush && (mem_hold || load_use);

  // ---- p1: EX slot register; flush > hold > load-use bubble > capture ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= EX_CTRL_BUBBLE;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      pc_p1       <= '0;
    end else if (ex_flush || (!mem_hold && load_use)) begin
      vld_p1      <= 1'b0;
      ctrl_p1     <= EX_CTRL_BUBBLE;
      rs1_p1      <= '0;
      rs2_p1      <= '0;
      rd_p1       <= '0;
      rs1_data_p1 <= '0;
      rs2_data_p1 <= '0;
      imm_p1      <= '0;
      pc_p1       <= '0;
    end else if (!mem_hold) begin
      vld_p1      <= id_valid;
      ctrl_p1     <= ctrl_p0;
      rs1_p1      <= id_rs1;
      rs2_p1      <= id_rs2;
      rd_p1       <= id_rd;
      rs1_data_p1 <= id_rs1_data;
      rs2_data_p1 <= id_rs2_data;
      imm_p1      <= id_imm;
      pc_p1       <= id_pc;
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_ex        = ctrl_p1.ex;
  assign ex_jump_t    = ctrl_p1.jump_t;
  assign ex_slt       = ctrl_p1.slt;
  assign ex_lui       = ctrl_p1.lui;
  assign ex_mem_read  = ctrl_p1.mem_read;
  assign ex_mem_write = ctrl_p1.mem_write;
  assign ex_reg_write = ctrl_p1.reg_write;
  assign ex_rs1       = rs1_p1;
  assign ex_rs2       = rs2_p1;
  assign ex_rd        = rd_p1;
  assign ex_rs1_data  = rs1_data_p1;
  assign ex_rs2_data  = rs2_data_p1;
  assign ex_imm       = imm_p1;
  assign ex_pc        = pc_p1;

`ifdef ID_EX_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
    end else begin
      if (!ex_flush && !mem_hold && load_use) perf_bubble_cnt <= sat_inc(perf_bubble_cnt);
      if (ex_flush)                           perf_flush_cnt  <= sat_inc(perf_flush_cnt);
    end
  end
`endif

endmodule

// File: doc/id_ex_ctrl_pipe.md
Name: id_ex_ctrl_pipe

Overview:
ID→EX pipeline stage that transmits the decoded execute-control bundle and operands to the execute stage, where they drive the EX control decode and mux selects. Owns load-use hazard detection, bubble insertion, hold under memory stall, and flush on taken jump/branch. Sits between the decode control unit and the EX control/ALU path.

Parameters:
XLEN, 32, datapath width of operands, immediate and PC
REG_AW, 5, register-index width

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  decode slot holds a real instruction
id_ex  in  3  EX/ALU opcode field; bit2 selects immediate operand
id_jump_t  in  2  jump type: 00 none, 01 JAL, 10 JALR, 11 BRANCH
id_slt, id_lui  in  1 each  result-select hints
id_mem_read, id_mem_write, id_reg_write  in  1 each  memory/writeback controls
id_use_rs1, id_use_rs2  in  1 each  instruction reads rs1/rs2
id_rs1, id_rs2, id_rd  in  REG_AW each  register indices
id_rs1_data, id_rs2_data, id_imm, id_pc  in  XLEN each  operands and PC
ex_flush  in  1  taken jump/branch resolved in EX; kill younger instructions
mem_hold  in  1  downstream stall; freeze this stage
stall_id  out  1  hold PC and IF/ID register this cycle
ex_valid  out  1  EX slot valid
ex_ex, ex_jump_t, ex_slt, ex_lui, ex_mem_read, ex_mem_write, ex_reg_write  out  match inputs  registered controls
ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  match inputs  registered operands

Behaviour:
- Reset (async, rst=1): all outputs registered to 0. The EX slot holds a bubble with jump_t=00.
- Bubble definition: ex_valid=0; ex_jump_t=00; ex_reg_write, ex_mem_read and ex_mem_write = 0; ex_ex, ex_slt and ex_lui = 0. Data fields are don't-care, but RTL drives them to 0.
- load_use (combinational) = ex_valid & ex_mem_read & (ex_rd!=0) & id_valid & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- stall_id (combinational) = !ex_flush & (mem_hold | load_use).
- Register update priority, evaluated each rising edge:
  1. ex_flush=1: load a bubble. The IF/ID flush is handled upstream, so stall_id=0.
  2. mem_hold=1: all EX registers keep their value.
  3. load_use=1: load a bubble. The ID instruction is retained upstream via stall_id and captured one cycle later.
  4. Otherwise: capture all id_* fields; ex_valid<=id_valid.
- When id_valid=0, the EX control bits are forced to the bubble values regardless of the id_* control inputs.
- Latency: 1 cycle from ID capture to EX outputs. A load-use costs exactly 1 bubble cycle. After the bubble, ex_rd no longer matches the load, so the stall clears automatically.
- rd=0 never causes a stall.
- ex_flush and load_use in the same cycle: flush wins and no stall is issued.
- ex_flush and mem_hold in the same cycle: flush wins and the bubble is loaded.
- rst asserted mid-hold: outputs go to 0 immediately; stall_id falls after rst because ex_valid=0.

Optional Feature:
ID_EX_PERF_CNT_EN
- Defined: adds outputs perf_bubble_cnt[31:0] and perf_flush_cnt[31:0].
  - perf_bubble_cnt increments on each edge where a load_use bubble is loaded.
  - perf_flush_cnt increments on each edge where ex_flush=1.
  - Both counters saturate at 32'hFFFF_FFFF and reset to 0 on rst.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package holds:
  - jump_t encodings: JT_NONE=2'b00, JT_JAL=2'b01, JT_JALR=2'b10, JT_BRANCH=2'b11.
  - The ex opcode width constant.
  - A struct/bundle typedef for the EX control fields, used by both decode and EX.
- One natural sub-module: load_use_detect, the purely combinational hazard compare. The register and priority logic stays in the top.

Test Plan:
1. Reset: rst=1 with all id_* set to 1 → all outputs 0, ex_jump_t=00, stall_id=0.
2. Normal flow: id_valid=1, id_ex=3'b101, id_jump_t=11, id_rd=5 → next cycle ex_ex=101, ex_jump_t=11, ex_rd=5, ex_valid=1.
3. Load-use: EX holds a load with rd=7; ID has use_rs2=1, rs2=7 → stall_id=1; next cycle a bubble (ex_valid=0, ex_reg_write=0); then the ID instruction appears with stall_id=0.
4. No false stall: same as 3 but use_rs2=0, or rd=0 → stall_id=0; no bubble.
5. Flush priority: ex_flush=1 together with load_use=1 and mem_hold=1 → stall_id=0; next cycle a bubble with ex_jump_t=00.
6. Hold: mem_hold=1 for 3 cycles with varying id_* inputs → EX outputs constant and stall_id=1; on release, the current id_* values are captured.
